// File: rtl/argmax_pkg.sv
// argmax_pkg: shared fp32 width, controller state encoding and NaN helper for the argmax stage.
package argmax_pkg;
  localparam int FP32_W = 32;
  typedef enum logic {ACC, OUT} state_t;
  function automatic logic is_nan(input logic [FP32_W-1:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction
endpackage

// File: rtl/fp32_cmp.sv
// fp32_cmp: IEEE-754 single-precision compare; NaN compares false, +0 equals -0.
module fp32_cmp
  import argmax_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic              a_gt_b,
  output logic              a_eq_b
);
  logic any_nan, both_zero, mag_gt;
  assign any_nan   = is_nan(a) | is_nan(b);
  assign both_zero = ~|a[30:0] & ~|b[30:0];
  // Sign-magnitude order: for negatives the smaller magnitude is the larger value.
  assign mag_gt    = (a[31] != b[31]) ? ~a[31] :
                     a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
  assign a_gt_b    = ~any_nan & ~both_zero & mag_gt;
  assign a_eq_b    = ~any_nan & (both_zero | (a == b));
endmodule

// File: rtl/argmax_seq.sv
// argmax_seq: streams fp32 logits through one shared comparator and emits the winning class
// on a valid/ready handshake once N_CLASSES beats have been accepted.
module argmax_seq
  import argmax_pkg::*;
#(
  parameter int N_CLASSES = 10,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FP32_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [IDX_W-1:0]  m_class,
  output logic [FP32_W-1:0] m_score,
  output logic              frame_err
);
  state_t              state;
  logic [IDX_W-1:0]    cnt, best_idx, win_idx;
  logic [FP32_W-1:0]   best, win_score;
  logic                accept, last_beat, gt, eq, upd;
  fp32_cmp u_cmp (.a(s_data), .b(best), .a_gt_b(gt), .a_eq_b(eq));
  assign m_valid   = state == OUT;
  assign s_ready   = (state == ACC) | (m_valid & m_ready);
  assign accept    = s_valid & s_ready;
  assign last_beat = cnt == IDX_W'(N_CLASSES - 1);
  // Strictly greater only, so ties and +0/-0 keep the earlier class.
  assign upd       = (cnt == '0) | (~is_nan(s_data) & (is_nan(best) | (gt & ~eq)));
  assign win_idx   = upd ? cnt : best_idx;
  assign win_score = upd ? s_data : best;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      cnt       <= '0;
      best      <= '0;
      best_idx  <= '0;
      m_class   <= '0;
      m_score   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept & (s_last != last_beat);
      if (state == OUT && m_ready) state <= ACC;
      if (accept) begin
        cnt <= last_beat ? '0 : cnt + 1'b1;
        if (upd) begin
          best     <= s_data;
          best_idx <= cnt;
        end
        if (last_beat) begin
          state   <= OUT;
          m_class <= win_idx;
          m_score <= win_score;
        end
      end
    end
  end
endmodule

// File: tb/tb_argmax_seq.sv
// tb_argmax_seq: scoreboard bench for argmax_seq; expected winners come from an independent fp32 ordering model.
module tb_argmax_seq;
  localparam int N = 10;
  typedef logic [31:0] frame_t [N];
  typedef struct {logic [3:0] cls; logic [31:0] score;} exp_t;
  logic clk = 0, rst_n = 0, s_valid = 0, s_ready, s_last = 0, m_valid, m_ready = 0, frame_err;
  logic [31:0] s_data = '0, m_score;
  logic [3:0] m_class;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0, errs = 0;
  always #5 clk = ~clk;
  argmax_seq #(.N_CLASSES(N), .IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class),
    .m_score(m_score), .frame_err(frame_err));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 0;
  endfunction
  function automatic logic [31:0] key(input logic [31:0] x);
    logic [31:0] y;
    y = (x == 32'h8000_0000) ? 32'h0 : x;
    return y[31] ? ~y : (y | 32'h8000_0000);
  endfunction
  function automatic exp_t model(input frame_t d);
    exp_t e;
    logic have;
    int bi;
    bi = 0;
    have = !nan(d[0]);
    for (int i = 1; i < N; i++)
      if (!nan(d[i]) && (!have || key(d[i]) > key(d[bi]))) begin
        bi = i;
        have = 1;
      end
    e.cls = 4'(bi);
    e.score = d[bi];
    return e;
  endfunction
  function automatic frame_t mk(input logic [31:0] base, input int i0, input logic [31:0] v0,
                                input int i1, input logic [31:0] v1);
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = base;
    if (i0 >= 0) f[i0] = v0;
    if (i1 >= 0) f[i1] = v1;
    return f;
  endfunction
  task automatic send_beat(input logic [31:0] d, input logic l);
    logic ok;
    int n;
    s_valid = 1;
    s_data = d;
    s_last = l;
    n = 0;
    do begin
      @(negedge clk) ok = s_ready;
      @(posedge clk) #1;
      cyc++;
      n++;
    end while (!ok && n < 200);
    if (!ok) check("beat_accept_timeout", 0, 1);
  endtask
  task automatic send_frame(input frame_t d, input logic [N-1:0] lastm);
    sb.push_back(model(d));
    for (int i = 0; i < N; i++) send_beat(d[i], lastm[i]);
    s_valid = 0;
    s_last = 0;
  endtask
  always @(negedge clk) begin
    if (frame_err) errs++;
    if (m_valid && m_ready) begin
      if (sb.size() == 0) check("unexpected_result", 1, 0);
      else begin
        check("m_class", 32'(m_class), 32'(sb[0].cls));
        check("m_score", m_score, sb[0].score);
        void'(sb.pop_front());
      end
    end
  end
  localparam logic [N-1:0] LAST9 = 10'b10_0000_0000;
  initial begin
    int c0, e0;
    exp_t ex;
    #12;
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_s_ready", 32'(s_ready), 1);
    rst_n = 1;
    @(posedge clk) #1;
    e0 = errs;
    send_frame(mk(32'h3F00_0000, 7, 32'h4000_0000, -1, 0), LAST9);
    @(negedge clk);
    check("latency_m_valid", 32'(m_valid), 1);
    @(posedge clk) #1;
    m_ready = 1;
    send_frame(mk(32'hBF80_0000, 3, 32'hBF00_0000, -1, 0), LAST9);
    send_frame(mk(32'hBF80_0000, 0, 32'h8000_0000, 1, 32'h0000_0000), LAST9);
    send_frame(mk(32'h3F00_0000, 0, 32'h7FC0_0000, 4, 32'h3F80_0000), LAST9);
    send_frame(mk(32'h7FC0_0000, 5, 32'h7F80_0001, -1, 0), LAST9);
    repeat (3) @(posedge clk);
    #1;
    check("no_frame_err", 32'(errs - e0), 0);
    m_ready = 0;
    send_frame(mk(32'h4100_0000, 9, 32'h4110_0000, 2, 32'hC200_0000), LAST9);
    ex = sb[0];
    repeat (5) begin
      @(negedge clk);
      check("bp_m_valid", 32'(m_valid), 1);
      check("bp_s_ready", 32'(s_ready), 0);
      check("bp_m_class", 32'(m_class), 32'(ex.cls));
      check("bp_m_score", m_score, ex.score);
    end
    @(posedge clk) #1;
    m_ready = 1;
    c0 = cyc;
    send_frame(mk(32'h3F80_0000, 0, 32'h4080_0000, 6, 32'h4040_0000), LAST9);
    check("overlap_cycles", 32'(cyc - c0), N);
    c0 = cyc;
    send_frame(mk(32'h0000_0001, 8, 32'h0000_0002, -1, 0), LAST9);
    send_frame(mk(32'hC000_0000, 2, 32'hBFFF_FFFF, 5, 32'hBFFF_FFFF), LAST9);
    send_frame(mk(32'h7F7F_FFFF, 0, 32'hFF80_0000, 9, 32'h7F80_0000), LAST9);
    check("b2b_cycles", 32'(cyc - c0), 3 * N);
    e0 = errs;
    send_frame(mk(32'h3E00_0000, 1, 32'h3F00_0000, -1, 0), 10'b00_0001_0000);
    repeat (3) @(posedge clk);
    #1;
    check("frame_err_pulses", 32'(errs - e0), 2);
    for (int i = 0; i < 6; i++) send_beat(32'h4200_0000 + 32'(i), 1'b0);
    s_valid = 0;
    rst_n = 0;
    #2;
    check("arst_m_valid", 32'(m_valid), 0);
    check("arst_m_class", 32'(m_class), 0);
    check("arst_m_score", m_score, 0);
    check("arst_frame_err", 32'(frame_err), 0);
    check("arst_s_ready", 32'(s_ready), 1);
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;
    send_frame(mk(32'h3F00_0000, 2, 32'h3F40_0000, -1, 0), LAST9);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/argmax_seq.md
# argmax_seq

Sequential argmax controller for the classifier output stage. It accepts the final-layer fp32 logits as a stream of one per cycle and keeps a running maximum through a single shared `fp32_cmp`. After the N-th logit it presents the winning class index and its score on a valid/ready output. It replaces the wide one-shot comparator tree, so that only one comparator is instantiated, and it gives the top level a proper completion handshake.

## Interface
- `N_CLASSES`, default 10: logits per frame (≥2).
- `IDX_W`, default 4: class index width (≥ clog2(N_CLASSES)).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  logit beat valid.
- `s_ready`  out  1  block can accept a beat.
- `s_data`  in  32  IEEE-754 fp32 logit. Beat k of a frame is class k.
- `s_last`  in  1  upstream end-of-frame marker (checked only, never used for framing).
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumed.
- `m_class`  out  IDX_W  index of the maximum logit.
- `m_score`  out  32  fp32 value of the maximum logit.
- `frame_err`  out  1  one-cycle pulse on an `s_last` framing mismatch.

## Operation
- States: ACC (collecting) and OUT (result held). Reset state is ACC, with `cnt`=0.
- Accept: `s_ready & s_valid`. `s_ready` = (state==ACC) | (m_valid & m_ready).
- On accept, `best`/`best_idx` update when any of these holds:
  - `cnt`==0 (load unconditionally).
  - `best` is NaN and `s_data` is not NaN.
  - `s_data` is not NaN and `fp32_cmp(s_data, best).a_gt_b`.
- Strict greater-than only. Ties keep the earlier (lower) index. +0 and −0 are equal. NaN never wins against a number.
- If every beat of a frame is NaN, the result is class 0.
- `cnt` increments on each accept. On the accept with `cnt`==N_CLASSES−1, `cnt` resets to 0 and the state goes to OUT. `m_class`/`m_score` are loaded with the final winner, including the final beat's own comparison.
- In OUT: `m_valid`=1, and outputs stay stable until `m_ready`. On `m_valid & m_ready` the state returns to ACC.
  - A beat accepted in that same cycle is beat 0 of the next frame.
- `frame_err` is pulsed for one cycle on any of these accepts:
  - `s_last`=1 with `cnt`≠N_CLASSES−1.
  - `s_last`=0 with `cnt`==N_CLASSES−1.
- Framing is always by count.

## Timing
- Reset values: `m_valid`=0, `m_class`=0, `m_score`=32'h0, `frame_err`=0, state ACC, `cnt`=0, so `s_ready`=1.
- Asynchronous reset mid-frame discards the partial frame. The next accepted beat is class 0.
- Latency: `m_valid` rises on the clock edge after the last beat is accepted.
- Throughput: one frame per N_CLASSES cycles when `m_ready` is held high (overlap rule above). There are no bubbles.
- Comparator path: `s_data` through `fp32_cmp` to the `best` register in a single cycle. No output is driven combinationally from `s_data`.
- `m_class`/`m_score` change only on entry to OUT.

## Structure
- Package `argmax_pkg`:
  - `FP32_W`=32.
  - State enum {ACC, OUT}.
  - `is_nan` function: exponent all ones and mantissa≠0.
- Sub-module: the existing `fp32_cmp` (ports `a`, `b`, `a_gt_b`, `a_eq_b`), instantiated once, with `a`=`s_data` and `b`=`best`.
- Everything else lives in this module: the FSM, the frame counter and the best/best_idx registers.

## Test plan
- Ten beats of 3F000000 (0.5) with class 7=40000000 (2.0), `s_last` on beat 9 → `m_valid` one cycle later, `m_class`=7, `m_score`=40000000, `frame_err` never pulses.
- All beats BF800000 (−1.0) except class 3=BF000000 (−0.5) → `m_class`=3. Separately, class 0=80000000 (−0) and class 1=00000000 (+0), rest −1.0 → `m_class`=0 (tie keeps the earlier index).
- Class 0=7FC00000 (NaN), class 4=3F800000, rest 3F000000 → `m_class`=4. All-NaN frame → `m_class`=0.
- Backpressure: `m_ready`=0 for 5 cycles → `m_valid`, `m_class` and `m_score` stay stable and `s_ready`=0. Then raise `m_ready` while the next frame's beat 0 is valid → the beat is accepted. Three back-to-back frames complete in 30 cycles.
- `s_last` asserted on beat 4 and absent on beat 9 → two single-cycle `frame_err` pulses, and the result still appears after beat 9.
- Assert `rst_n` low after 6 beats → all outputs return to their reset values. The next 10 beats give a correct, independent result.
